// File: rtl/irq_controller_if.sv
// Wishbone slave bus of the interrupt controller, grouped for port hookup.
interface irq_controller_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: per-source edge/level pending capture, enable mask,
// priority claim register and a Wishbone slave port with single-cycle ack.
module irq_controller #(
    parameter int unsigned NUM_SOURCES = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    irq_controller_if.slave        wb,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    output logic                   irq_o
);
    localparam int unsigned N  = NUM_SOURCES;
    localparam int unsigned CW = 5;

    localparam logic [1:0] WORD_PENDING = 2'd0;
    localparam logic [1:0] WORD_ENABLE  = 2'd1;
    localparam logic [1:0] WORD_CLAIM   = 2'd2;
    localparam logic [1:0] WORD_MODE    = 2'd3;

    logic [N-1:0] pending_q, enable_q, mode_q, prev_q;
    logic [N-1:0] pending_d, enable_d, mode_d;
    logic         ack_q, ack_d;
    logic [31:0]  rdata_q, rdata_d;

    logic         req, wr, rd;
    logic [1:0]   word;
    logic [31:0]  byte_mask;
    logic [N-1:0] wmask, wdata, active, claim_hot, clr, rise, set;
    logic [CW-1:0] claim_id;
    logic [31:0]  rdata;

    // Bus decode, claim priority encoder and next-state of every register.
    always_comb begin
        req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        wr        = req & wb.wb_we_i;
        rd        = req & ~wb.wb_we_i;
        word      = wb.wb_adr_i[3:2];
        byte_mask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                     {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
        wmask     = N'(byte_mask);
        wdata     = N'(wb.wb_dat_i);
        active    = pending_q & enable_q;

        // Scan from the top so the lowest active index is the last one written.
        claim_id  = '0;
        claim_hot = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id     = CW'(i + 1);
                claim_hot    = '0;
                claim_hot[i] = 1'b1;
            end
        end

        clr = '0;
        if (wr && word == WORD_PENDING) clr = clr | (wdata & wmask);
        if (rd && word == WORD_CLAIM)   clr = clr | claim_hot;

        // Level sources re-set every cycle they are high, so set beats clear.
        rise      = irq_src_i & ~prev_q;
        set       = (mode_q & rise) | (~mode_q & irq_src_i);
        pending_d = (pending_q & ~clr) | set;

        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr && word == WORD_ENABLE) enable_d = (enable_q & ~wmask) | (wdata & wmask);
        if (wr && word == WORD_MODE)   mode_d   = (mode_q & ~wmask) | (wdata & wmask);

        rdata = '0;
        case (word)
            WORD_PENDING: rdata = 32'(pending_q);
            WORD_ENABLE:  rdata = 32'(enable_q);
            WORD_CLAIM:   rdata = 32'(claim_id);
            WORD_MODE:    rdata = 32'(mode_q);
            default:      rdata = '0;
        endcase

        rdata_d = rd ? rdata : '0;
        ack_d   = req;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '1;
            prev_q    <= '0;
            irq_o     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            prev_q    <= irq_src_i;
            irq_o     <= |active;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i, byte_mask};
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed corner
// sequences and randomized traffic against a per-source reference model.
module tb_irq_controller;
    logic       clk_i;
    logic       reset_i;
    logic [7:0] src;
    logic       irq_o;
    int         checks;
    int         errors;
    bit         chk_en;

    irq_controller_if bus ();

    irq_controller #(.NUM_SOURCES(8)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wb        (bus),
        .irq_src_i (src),
        .irq_o     (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: state kept as plain per-source bits.
    logic [7:0]  m_pend, m_en, m_mode, m_prev;
    bit          m_ack, m_irq;
    logic [31:0] m_dat;

    always @(posedge clk_i) begin : model
        bit          req, found, rising, setb;
        logic [1:0]  w;
        logic [31:0] claim, rdv;
        logic [7:0]  clr, np;
        if (reset_i) begin
            m_pend = 8'h00; m_en = 8'h00; m_mode = 8'hFF; m_prev = 8'h00;
            m_ack = 1'b0; m_irq = 1'b0; m_dat = 32'h0;
        end else begin
            req   = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            w     = bus.wb_adr_i[3:2];
            claim = 0;
            found = 1'b0;
            for (int i = 0; i < 8; i++)
                if (!found && m_pend[i] && m_en[i]) begin
                    claim = i + 1;
                    found = 1'b1;
                end
            case (w)
                2'd0:    rdv = {24'h0, m_pend};
                2'd1:    rdv = {24'h0, m_en};
                2'd2:    rdv = claim;
                default: rdv = {24'h0, m_mode};
            endcase
            clr = 8'h00;
            if (req && bus.wb_we_i && w == 2'd0 && bus.wb_sel_i[0]) clr = bus.wb_dat_i[7:0];
            if (req && !bus.wb_we_i && w == 2'd2 && found) clr = clr | (8'd1 << (claim - 1));
            for (int i = 0; i < 8; i++) begin
                rising = src[i] && !m_prev[i];
                setb   = m_mode[i] ? rising : src[i];
                np[i]  = setb ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
            end
            m_irq = |(m_pend & m_en);
            m_dat = (req && !bus.wb_we_i) ? rdv : 32'h0;
            m_ack = req;
            if (req && bus.wb_we_i && w == 2'd1 && bus.wb_sel_i[0]) m_en   = bus.wb_dat_i[7:0];
            if (req && bus.wb_we_i && w == 2'd3 && bus.wb_sel_i[0]) m_mode = bus.wb_dat_i[7:0];
            m_pend = np;
            m_prev = src;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model_ack", {31'h0, bus.wb_ack_o}, {31'h0, m_ack});
            check("model_dat", bus.wb_dat_o, m_dat);
            check("model_irq", {31'h0, irq_o}, {31'h0, m_irq});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic xfer(input bit we, input logic [3:0] adr, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = d;    bus.wb_sel_i = sel;
        got  = 1'b0;
        rdat = 32'h0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.wb_ack_o) begin
                rdat = bus.wb_dat_o;
                got  = 1'b1;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: no ack within 8 cycles at adr 0x%0h", adr);
        end
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, adr, d, 4'hF, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        xfer(1'b0, adr, 32'h0, 4'hF, v);
        check(name, v, exp);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [31:0] v;
        checks = 0; errors = 0; chk_en = 1'b0;
        reset_i = 1'b1; src = 8'h00;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 4'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'h0;
        tick();
        chk_en = 1'b1;
        tick();
        reset_i = 1'b0;

        check("reset_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("reset_irq", {31'h0, irq_o}, 32'h0);
        rd_chk("reset_mode", 4'hC, 32'hFF);

        tbl[0]  = '{1'b1, 4'h4, 32'h0000_00A5, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 4'h4, 32'h0,         4'hF, 32'hA5};
        tbl[2]  = '{1'b1, 4'h4, 32'h1234_5600, 4'h1, 32'h0};
        tbl[3]  = '{1'b0, 4'h6, 32'h0,         4'hF, 32'h0};
        tbl[4]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'hE, 32'h0};
        tbl[5]  = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0};
        tbl[6]  = '{1'b1, 4'hC, 32'h0000_000F, 4'h1, 32'h0};
        tbl[7]  = '{1'b0, 4'hC, 32'h0,         4'hF, 32'h0F};
        tbl[8]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hE, 32'h0};
        tbl[9]  = '{1'b0, 4'hF, 32'h0,         4'hF, 32'h0F};
        tbl[10] = '{1'b1, 4'hC, 32'h0000_00FF, 4'h1, 32'h0};
        tbl[11] = '{1'b0, 4'hC, 32'h0,         4'hF, 32'hFF};
        tbl[12] = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h0};
        tbl[14] = '{1'b0, 4'h1, 32'h0,         4'hF, 32'h0};
        tbl[15] = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[16] = '{1'b0, 4'h5, 32'h0,         4'hF, 32'hFF};
        tbl[17] = '{1'b1, 4'h4, 32'h0,         4'hF, 32'h0};
        for (int i = 0; i < 18; i++) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, v);
            if (!tbl[i].we) check($sformatf("table_%0d", i), v, tbl[i].exp);
        end

        // Single edge source: latency, pending, claim and irq drop.
        do_reset();
        wr(4'h4, 32'h01);
        src = 8'h01;
        tick();
        check("irq_1cyc_after_pulse", {31'h0, irq_o}, 32'h0);
        src = 8'h00;
        tick();
        check("irq_2cyc_after_pulse", {31'h0, irq_o}, 32'h1);
        rd_chk("pending_src0", 4'h0, 32'h1);
        rd_chk("claim_src0", 4'h8, 32'h1);
        tick();
        check("irq_after_claim", {31'h0, irq_o}, 32'h0);

        // Two simultaneous sources claimed in priority order.
        wr(4'h4, 32'hFF);
        src = 8'h24;
        tick();
        src = 8'h00;
        tick();
        check("irq_two_src", {31'h0, irq_o}, 32'h1);
        rd_chk("claim_first", 4'h8, 32'h3);
        rd_chk("claim_second", 4'h8, 32'h6);
        tick();
        check("irq_after_second_claim", {31'h0, irq_o}, 32'h0);
        rd_chk("claim_empty", 4'h8, 32'h0);

        // Level source held high survives W1C until it drops.
        do_reset();
        wr(4'hC, 32'hFD);
        src = 8'h02;
        tick();
        tick();
        wr(4'h0, 32'h2);
        rd_chk("level_w1c_held", 4'h0, 32'h2);
        src = 8'h00;
        wr(4'h0, 32'h2);
        rd_chk("level_w1c_released", 4'h0, 32'h0);

        // Edge arriving on the same edge as a W1C of that bit wins.
        do_reset();
        src = 8'h08;
        tick();
        src = 8'h00;
        tick();
        src = 8'h08;
        wr(4'h0, 32'h8);
        src = 8'h00;
        rd_chk("set_beats_w1c", 4'h0, 32'h8);
        wr(4'h0, 32'h8);
        rd_chk("w1c_clears", 4'h0, 32'h0);

        // Masked source stays pending and fires once enabled.
        do_reset();
        src = 8'h10;
        tick();
        src = 8'h00;
        tick();
        tick();
        check("masked_irq", {31'h0, irq_o}, 32'h0);
        rd_chk("masked_pending", 4'h0, 32'h10);
        wr(4'h4, 32'h10);
        check("irq_at_enable_ack", {31'h0, irq_o}, 32'h0);
        tick();
        check("irq_after_enable", {31'h0, irq_o}, 32'h1);

        // Reset hitting an outstanding request.
        do_reset();
        wr(4'h4, 32'hFF);
        wr(4'hC, 32'h0F);
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 4'h4;
        reset_i = 1'b1;
        tick();
        check("rst_no_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rst_dat_zero", bus.wb_dat_o, 32'h0);
        tick();
        check("rst_no_ack2", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        reset_i = 1'b0;
        tick();
        rd_chk("rst_pending", 4'h0, 32'h0);
        rd_chk("rst_enable", 4'h4, 32'h0);
        rd_chk("rst_claim", 4'h8, 32'h0);
        rd_chk("rst_mode", 4'hC, 32'hFF);

        // Source high across reset release registers as an edge but stays masked.
        src = 8'h40;
        do_reset();
        tick();
        src = 8'h00;
        rd_chk("held_thru_reset_pending", 4'h0, 32'h40);
        check("held_thru_reset_irq", {31'h0, irq_o}, 32'h0);
        wr(4'h4, 32'h40);
        tick();
        check("held_thru_reset_enabled", {31'h0, irq_o}, 32'h1);

        // Randomized traffic, compared every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            src          = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            bus.wb_cyc_i = 1'($urandom_range(0, 1));
            bus.wb_stb_i = 1'($urandom_range(0, 1));
            bus.wb_we_i  = 1'($urandom_range(0, 1));
            bus.wb_adr_i = 4'($urandom);
            bus.wb_dat_i = $urandom;
            bus.wb_sel_i = 4'($urandom);
            reset_i      = ($urandom_range(0, 127) == 0);
            tick();
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        reset_i = 1'b0;
        src = 8'h00;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
